nexys4_debounce: RTL and testbench
==================================

// Module: nexys4_debounce
// PURPOSE
//  Input conditioning stage feeding the PicoBlaze bot I/O interface.
//  - Synchronises and debounces the six raw Nexys4 pushbuttons and 16 slide switches.
//  - Debounced levels drive dbbtns[5:0] and Switches[15:0] of the I/O interface.
//  - Also emits one-cycle press pulses for firmware or other logic.
//  - A shared prescaler gives the sample tick. Each input has its own stability counter.
// PARAMETERS
//  TICK_DIV     100000  sysclk cycles per sample tick (1 ms at 100 MHz); legal >= 1
//  STABLE_CNT   5       consecutive disagreeing ticks required to accept a new level; legal >= 1
//  NBTNS        6       number of pushbutton inputs
//  NSW          16      number of switch inputs
// PORTS
//  sysclk       in   1      system clock, all logic on rising edge
//  sysreset_n   in   1      synchronous reset, active-low
//  pbtn_in      in   NBTNS  raw pushbuttons, active-high (top inverts btnCpuReset before this port)
//  switch_in    in   NSW    raw slide switches
//  pbtn_db      out  NBTNS  debounced pushbutton levels (to dbbtns)
//  swtch_db     out  NSW    debounced switch levels (to Switches)
//  btn_press    out  NBTNS  one-sysclk pulse on each 0->1 edge of pbtn_db
//  sample_tick  out  1      one-sysclk prescaler tick, for observation
// BEHAVIOUR
//  Reset (sysreset_n == 0 at a sysclk edge):
//  - Synchroniser flops, prescaler, all stability counters, pbtn_db, swtch_db, btn_press
//    and sample_tick all go to 0.
//  - Reset has priority over every other event. Asserting it mid-count discards the
//    partial count.
//  Synchroniser:
//  - Two flops per input (NBTNS+NSW bits). The sync output lags the raw input by 2 cycles.
//  Prescaler:
//  - Counts 0..TICK_DIV-1 and wraps to 0.
//  - sample_tick is registered high for exactly the cycle after the count equals TICK_DIV-1.
//  - TICK_DIV==1 makes sample_tick high every cycle after reset.
//  Per-input filter, width $clog2(STABLE_CNT+1); action taken only on cycles with sample_tick==1:
//  - sync == db: cnt <= 0.
//  - sync != db and cnt == STABLE_CNT-1: db <= sync, cnt <= 0.
//  - otherwise: cnt <= cnt+1.
//  - Any single agreeing tick (a bounce back) clears cnt. Acceptance needs an unbroken run
//    of STABLE_CNT disagreeing ticks.
//  - STABLE_CNT==1 accepts on the first disagreeing tick.
//  - Filtering is symmetric for press and release.
//  - Inputs are independent. Simultaneous changes on any subset resolve in parallel,
//    with no arbitration.
//  Latency:
//  - A clean raw step reaches db between 3+(STABLE_CNT-1)*TICK_DIV and
//    3+STABLE_CNT*TICK_DIV cycles after the step, depending on the prescaler phase.
//  btn_press:
//  - btn_press[i] = registered (pbtn_db[i] & ~pbtn_db_prev[i]).
//  - It is high exactly one cycle, the cycle after pbtn_db[i] rises.
//  - No pulse on release. No pulse on reset exit.
//  - A new press is possible only after pbtn_db[i] has fallen and risen again.
//  Other rules:
//  - Raw inputs are asynchronous and may change on any cycle.
//  - No combinational path from any input to any output.
// TESTING  (bench uses TICK_DIV=4, STABLE_CNT=3 -> clean-step latency 11..15 cycles)
//  1. Reset: hold sysreset_n=0 5 cycles with pbtn_in=6'h3F, switch_in=16'hFFFF
//     -> all outputs 0 during reset and on the first cycle after release.
//  2. Clean press: pbtn_in[0] 0->1, held
//     -> pbtn_db[0] rises 11..15 cycles later.
//     -> btn_press[0] high exactly 1 cycle, the cycle after.
//     -> Release -> pbtn_db[0] falls 11..15 cycles later, no btn_press pulse.
//  3. Bounce: toggle pbtn_in[1] every 5 cycles for 60 cycles, then hold 0
//     -> pbtn_db[1] stays 0 throughout, btn_press[1] never asserts.
//  4. Switches: switch_in 16'h0000 -> 16'hA5C3 in one cycle
//     -> swtch_db == 16'hA5C3 within 15 cycles, with all bits changing on the same cycle.
//     -> Then 16'hA5C3 -> 16'h5A3C -> swtch_db == 16'h5A3C within 15 cycles.
//  5. Reset mid-count: step pbtn_in[2] to 1, pull sysreset_n low at cycle 8 for 1 cycle
//     -> pbtn_db[2] == 0 after reset.
//     -> It rises only 11..15 cycles after reset release, proving the count restarted.
//  6. Simultaneous: pbtn_in=6'b101010 and switch_in[15]=1 on the same cycle
//     -> pbtn_db=6'b101010 and swtch_db[15]=1 on the same cycle.
//     -> btn_press=6'b101010 for exactly one cycle.

Source files
------------

// File: rtl/nexys4_debounce_if.sv
// Raw/debounced button and switch bundle between the Nexys4 pins and the debounce stage.
// The master drives the raw levels and the slave (the debouncer) returns the conditioned ones.
interface nexys4_debounce_if #(
  parameter int NBTNS = 6,
  parameter int NSW   = 16
);
  logic [NBTNS-1:0] pbtn_in;
  logic [NSW-1:0]   switch_in;
  logic [NBTNS-1:0] pbtn_db;
  logic [NSW-1:0]   swtch_db;
  logic [NBTNS-1:0] btn_press;
  logic             sample_tick;

  modport master (
    output pbtn_in, switch_in,
    input  pbtn_db, swtch_db, btn_press, sample_tick
  );

  modport slave (
    input  pbtn_in, switch_in,
    output pbtn_db, swtch_db, btn_press, sample_tick
  );
endinterface

// File: rtl/nexys4_debounce.sv
// Synchronises and debounces the Nexys4 pushbuttons and slide switches for the PicoBlaze
// bot I/O, using one shared sample prescaler and a stability counter per input.
module nexys4_debounce #(
  parameter int TICK_DIV   = 100000,
  parameter int STABLE_CNT = 5,
  parameter int NBTNS      = 6,
  parameter int NSW        = 16
) (
  input  logic              sysclk,
  input  logic              sysreset_n,
  nexys4_debounce_if.slave  io
);
  localparam int NIN = NBTNS + NSW;
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW  = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CNT - 1);

  logic [NIN-1:0]   raw_s;
  logic [NIN-1:0]   meta_r;
  logic [NIN-1:0]   sync_r;
  logic [NIN-1:0]   db_r;
  logic [CW-1:0]    cnt_r [NIN];
  logic [PW-1:0]    presc_r;
  logic             tick_r;
  logic [NBTNS-1:0] db_prev_r;
  logic [NBTNS-1:0] press_r;

  // Switches occupy the upper bits so pushbuttons keep indices 0..NBTNS-1.
  assign raw_s = {io.switch_in, io.pbtn_in};

  // Two-flop synchroniser on every raw input.
  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= raw_s;
      sync_r <= meta_r;
    end
  end

  // Shared prescaler; the tick is registered so it lands one cycle after the terminal count.
  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      presc_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      tick_r  <= (presc_r == PRESC_LAST);
      presc_r <= (presc_r == PRESC_LAST) ? '0 : presc_r + PW'(1);
    end
  end

  // Per-input stability filter: an agreeing tick restarts the run, a full run flips the level.
  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      db_r <= '0;
      for (int i = 0; i < NIN; i++) cnt_r[i] <= '0;
    end else if (tick_r) begin
      for (int i = 0; i < NIN; i++) begin
        if (sync_r[i] == db_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          db_r[i]  <= sync_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end else begin
      db_r <= db_r;
    end
  end

  // Rising-edge detector on the debounced buttons; prev resets to 0 so reset exit is silent.
  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      db_prev_r <= '0;
      press_r   <= '0;
    end else begin
      db_prev_r <= db_r[NBTNS-1:0];
      press_r   <= db_r[NBTNS-1:0] & ~db_prev_r;
    end
  end

  assign io.pbtn_db     = db_r[NBTNS-1:0];
  assign io.swtch_db    = db_r[NIN-1:NBTNS];
  assign io.btn_press   = press_r;
  assign io.sample_tick = tick_r;
endmodule

// File: tb/tb_nexys4_debounce.sv
// Directed bench for nexys4_debounce with TICK_DIV=4, STABLE_CNT=3 (clean-step latency 11..15).
module tb_nexys4_debounce;
  logic sysclk;
  logic sysreset_n;
  int   n_checks;
  int   n_pass;

  nexys4_debounce_if #(.NBTNS(6), .NSW(16)) io ();

  nexys4_debounce #(.TICK_DIV(4), .STABLE_CNT(3), .NBTNS(6), .NSW(16)) dut (
    .sysclk     (sysclk),
    .sysreset_n (sysreset_n),
    .io         (io)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // One clock edge, then settle so sampling and driving stay away from the edge.
  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  function automatic logic [31:0] all_out();
    return {3'b000, io.btn_press, io.sample_tick, io.swtch_db, io.pbtn_db};
  endfunction

  task automatic run_until_btn(input int idx, input logic val, input int maxc,
                               output int n, output int npress);
    n = 0;
    npress = 0;
    do begin
      step();
      n++;
      if (io.btn_press[idx]) npress++;
    end while (io.pbtn_db[idx] !== val && n < maxc);
  endtask

  function automatic logic in_lat(input int n);
    return (n >= 11 && n <= 15);
  endfunction

  initial begin
    int n;
    int np;
    int bad;
    int ticks;
    n_checks   = 0;
    n_pass     = 0;
    sysreset_n = 1'b0;
    io.pbtn_in   = 6'h3F;
    io.switch_in = 16'hFFFF;

    // 1. reset with all inputs high
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rst_hold%0d", i), all_out(), 32'h0);
    end
    sysreset_n = 1'b1;
    step();
    check("rst_exit", all_out(), 32'h0);
    io.pbtn_in   = 6'h00;
    io.switch_in = 16'h0000;
    sysreset_n   = 1'b0;
    step();
    step();
    sysreset_n = 1'b1;
    step();

    // sample tick: one cycle in four
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (io.sample_tick) ticks++;
    end
    check("tick_count", 32'(ticks), 32'd10);

    // 2. clean press and release
    io.pbtn_in[0] = 1'b1;
    run_until_btn(0, 1'b1, 20, n, np);
    check("press_lat", {31'b0, in_lat(n)}, 32'd1);
    check("press_early", {31'b0, io.btn_press[0]}, 32'd0);
    step();
    check("press_pulse", {31'b0, io.btn_press[0]}, 32'd1);
    step();
    check("press_once", {31'b0, io.btn_press[0]}, 32'd0);
    io.pbtn_in[0] = 1'b0;
    run_until_btn(0, 1'b0, 20, n, np);
    check("rel_lat", {31'b0, in_lat(n)}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (io.btn_press[0]) np++;
    end
    check("rel_nopulse", 32'(np), 32'd0);

    // 3. bounce on button 1 never gets through
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      if (i < 60 && (i % 5) == 0) io.pbtn_in[1] = ~io.pbtn_in[1];
      if (i == 60) io.pbtn_in[1] = 1'b0;
      step();
      if (io.pbtn_db[1] || io.btn_press[1]) bad++;
    end
    check("bounce", 32'(bad), 32'd0);

    // 4. switches move as one word
    io.switch_in = 16'hA5C3;
    n = 0;
    do begin step(); n++; end while (io.swtch_db === 16'h0000 && n < 20);
    check("sw_a5c3", {16'h0, io.swtch_db}, 32'h0000A5C3);
    check("sw_a5c3_lat", {31'b0, in_lat(n)}, 32'd1);
    io.switch_in = 16'h5A3C;
    n = 0;
    do begin step(); n++; end while (io.swtch_db === 16'hA5C3 && n < 20);
    check("sw_5a3c", {16'h0, io.swtch_db}, 32'h00005A3C);
    check("sw_5a3c_lat", {31'b0, in_lat(n)}, 32'd1);

    // 5. reset mid-count discards the partial run
    io.pbtn_in[2] = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("midrst_pre", {31'b0, io.pbtn_db[2]}, 32'd0);
    sysreset_n = 1'b0;
    step();
    sysreset_n = 1'b1;
    check("midrst_db", {31'b0, io.pbtn_db[2]}, 32'd0);
    run_until_btn(2, 1'b1, 20, n, np);
    check("midrst_lat", {31'b0, in_lat(n)}, 32'd1);

    // 6. simultaneous buttons and switch bit 15
    io.pbtn_in = 6'b000000;
    for (int i = 0; i < 20; i++) step();
    io.pbtn_in       = 6'b101010;
    io.switch_in[15] = 1'b1;
    n = 0;
    do begin step(); n++; end while (io.pbtn_db === 6'b000000 && n < 20);
    check("simul_btn", {26'b0, io.pbtn_db}, 32'h2A);
    check("simul_sw15", {31'b0, io.swtch_db[15]}, 32'd1);
    step();
    check("simul_press", {26'b0, io.btn_press}, 32'h2A);
    step();
    check("simul_press_end", {26'b0, io.btn_press}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
